ref_window_row_streamer: RTL and testbench

//  Producer end of the interpolator row interface. On start, fetches a 15x15 reference

---
 rtl/ref_window_row_streamer.sv | 132 +++++++++++++
 tb/tb_ref_window_row_streamer.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/ref_window_row_streamer.sv
// Fetches a 15x15 reference pixel window from 64-bit word-addressed frame memory
// and streams it row by row to the interpolation core over a valid/ready handshake.
module ref_window_row_streamer #(
    parameter int PIX_W      = 8,
    parameter int ROW_PIX    = 15,
    parameter int NUM_ROWS   = 15,
    parameter int LINE_WORDS = 8,
    parameter int MEM_AW     = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     start,
    input  logic [11:0]              x0,
    input  logic [11:0]              y0,
    output logic                     busy,
    output logic                     done,
    output logic                     mem_rd_en,
    output logic [MEM_AW-1:0]        mem_addr,
    input  logic [63:0]              mem_rdata,
    output logic                     row_valid,
    input  logic                     row_ready,
    output logic [PIX_W*ROW_PIX-1:0] row_data,
    output logic [3:0]               row_idx,
    output logic                     last_row
);

    localparam int                ROW_W    = PIX_W * ROW_PIX;
    localparam logic [MEM_AW-1:0] LW       = MEM_AW'(LINE_WORDS);
    localparam logic [3:0]        LAST_IDX = 4'(NUM_ROWS - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_RD0,
        S_RD1,
        S_RD2,
        S_CAP,
        S_PRESENT,
        S_FIN
    } state_t;

    state_t state_q, state_d;

    logic [11:0]       x0_q;
    logic [MEM_AW-1:0] line_q;
    logic [63:0]       w0_q, w1_q;
    logic [1:0]        rd_k;
    logic [MEM_AW-1:0] line_base;
    logic [MEM_AW-1:0] col_word;
    logic [191:0]      window_bits;
    logic [ROW_W-1:0]  row_next;
    logic              handshake;

    assign line_base = line_q * LW;
    assign col_word  = MEM_AW'(x0_q[11:3]);

    // The third word arrives straight from memory in CAP, so it is never buffered.
    assign window_bits = {mem_rdata, w1_q, w0_q};
    assign row_next    = ROW_W'(window_bits >> (PIX_W * x0_q[2:0]));

    assign handshake = (state_q == S_PRESENT) && row_ready;

    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    always_comb begin
        state_d   = state_q;
        mem_rd_en = 1'b0;
        rd_k      = 2'd0;
        case (state_q)
            S_IDLE:    if (start) state_d = S_RD0;
            S_RD0: begin
                mem_rd_en = 1'b1;
                rd_k      = 2'd0;
                state_d   = S_RD1;
            end
            S_RD1: begin
                mem_rd_en = 1'b1;
                rd_k      = 2'd1;
                state_d   = S_RD2;
            end
            S_RD2: begin
                mem_rd_en = 1'b1;
                rd_k      = 2'd2;
                state_d   = S_CAP;
            end
            S_CAP:     state_d = S_PRESENT;
            S_PRESENT: if (row_ready) state_d = (row_idx == LAST_IDX) ? S_FIN : S_RD0;
            S_FIN:     state_d = S_IDLE;
            default:   state_d = S_IDLE;
        endcase
    end

    assign mem_addr  = mem_rd_en ? (line_base + col_word + MEM_AW'(rd_k)) : '0;
    assign row_valid = (state_q == S_PRESENT);
    assign last_row  = row_valid && (row_idx == LAST_IDX);
    assign busy      = (state_q != S_IDLE) && (state_q != S_FIN);
    assign done      = (state_q == S_FIN);

    // NOTE: sequential state uses non-blocking assignments only, so every register
    // samples the values from before the edge regardless of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_IDLE;
            x0_q     <= '0;
            line_q   <= '0;
            w0_q     <= '0;
            w1_q     <= '0;
            row_data <= '0;
            row_idx  <= '0;
        end else begin
            state_q <= state_d;
            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        x0_q    <= x0;
                        line_q  <= MEM_AW'(y0);
                        row_idx <= '0;
                    end
                end
                S_RD1:  w0_q     <= mem_rdata;
                S_RD2:  w1_q     <= mem_rdata;
                S_CAP:  row_data <= row_next;
                S_PRESENT: begin
                    if (handshake && (row_idx != LAST_IDX)) begin
                        line_q  <= line_q + MEM_AW'(1);
                        row_idx <= row_idx + 4'd1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_ref_window_row_streamer.sv
// Directed bench for ref_window_row_streamer: a behavioural frame memory where word a
// holds pixels 8a+p, with row contents, addresses and cycle timing checked per window.
module tb_ref_window_row_streamer;

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic [11:0]  x0, y0;
    logic         busy, done, mem_rd_en;
    logic [15:0]  mem_addr;
    logic [63:0]  mem_rdata = '0;
    logic         row_valid, row_ready;
    logic [119:0] row_data;
    logic [3:0]   row_idx;
    logic         last_row;

    int vectors     = 0;
    int miscompares = 0;
    int done_cnt    = 0;

    ref_window_row_streamer dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .x0        (x0),
        .y0        (y0),
        .busy      (busy),
        .done      (done),
        .mem_rd_en (mem_rd_en),
        .mem_addr  (mem_addr),
        .mem_rdata (mem_rdata),
        .row_valid (row_valid),
        .row_ready (row_ready),
        .row_data  (row_data),
        .row_idx   (row_idx),
        .last_row  (last_row)
    );

    always #5 clk = ~clk;

    function automatic logic [63:0] word_val(input logic [15:0] a);
        logic [63:0] w;
        for (int p = 0; p < 8; p++) w[8*p +: 8] = 8'((int'(a) * 8 + p) & 255);
        return w;
    endfunction

    // One-cycle read latency; idle cycles return a marker pattern rather than real data.
    always @(posedge clk) begin
        if (mem_rd_en) mem_rdata <= word_val(mem_addr);
        else           mem_rdata <= 64'hA5A5_5A5A_DEAD_BEEF;
        if (done) done_cnt++;
    end

    function automatic logic [119:0] exp_row(input int x, input int y, input int r);
        logic [119:0] v;
        for (int j = 0; j < 15; j++) v[8*j +: 8] = 8'((64 * (y + r) + x + j) & 255);
        return v;
    endfunction

    function automatic logic [15:0] exp_addr(input int x, input int y, input int r);
        return 16'(((y + r) * 8 + (x >> 3)) & 65535);
    endfunction

    task automatic check(input string tag, input logic [127:0] act, input logic [127:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_busy"},      busy,      0);
        check({tag, "_done"},      done,      0);
        check({tag, "_rd_en"},     mem_rd_en, 0);
        check({tag, "_addr"},      mem_addr,  0);
        check({tag, "_row_valid"}, row_valid, 0);
        check({tag, "_last_row"},  last_row,  0);
        check({tag, "_row_data"},  row_data,  0);
        check({tag, "_row_idx"},   row_idx,   0);
    endtask

    // Runs one window; optional stall row, start pulses on masked rows, or a reset abort.
    task automatic run_window(input int x, input int y, input int stall_row,
                              input int restart_mask, input int abort_row);
        int n, hs_n, d0, budget;
        d0        = done_cnt;
        start     = 1'b1;
        x0        = 12'(x);
        y0        = 12'(y);
        row_ready = 1'b1;
        tick();
        start = 1'b0;
        n     = 1;
        hs_n  = 0;
        check("busy_after_start", busy, 1);
        check("first_rd_en", mem_rd_en, 1);
        check("first_addr", mem_addr, exp_addr(x, y, 0));
        for (int r = 0; r < 15; r++) begin
            if (r == abort_row) begin
                tick();
                check("abort_rd1_addr", mem_addr, 16'(exp_addr(x, y, r) + 16'd1));
                rst = 1'b1;
                tick();
                rst = 1'b0;
                check_all_zero("abort");
                for (int k = 0; k < 6; k++) tick();
                check("abort_idle_busy", busy, 0);
                check("abort_no_done", done_cnt - d0, 0);
                return;
            end
            budget = 0;
            while (!row_valid && budget < 20) begin
                tick();
                n++;
                budget++;
            end
            check("row_valid_seen", row_valid, 1);
            if (r == 0) check("first_row_latency", n, 5);
            else        check("row_latency", n, hs_n + 5);
            check("row_data", row_data, exp_row(x, y, r));
            check("row_idx", row_idx, r);
            check("last_row", last_row, (r == 14));
            if (r == stall_row) begin
                row_ready = 1'b0;
                for (int k = 0; k < 10; k++) begin
                    tick();
                    n++;
                    check("stall_data", row_data, exp_row(x, y, r));
                    check("stall_idx", row_idx, r);
                    check("stall_rd_en", mem_rd_en, 0);
                    check("stall_valid", row_valid, 1);
                end
                row_ready = 1'b1;
            end
            if (restart_mask[r]) begin
                start = 1'b1;
                x0    = 12'(x) ^ 12'h5A5;
                y0    = 12'(y + 7);
            end
            hs_n = n;
            tick();
            n++;
            start = 1'b0;
            check("valid_drop", row_valid, 0);
            if (r < 14) begin
                check("next_rd_en", mem_rd_en, 1);
                check("next_addr", mem_addr, exp_addr(x, y, r + 1));
            end
        end
        check("done_cycle", n, 76 + ((stall_row >= 0) ? 10 : 0));
        check("done_pulse", done, 1);
        check("busy_at_fin", busy, 0);
        tick();
        check("done_cleared", done, 0);
        check("single_done", done_cnt - d0, 1);
    endtask

    initial begin
        rst       = 1'b1;
        start     = 1'b0;
        row_ready = 1'b0;
        x0        = '0;
        y0        = '0;
        tick();
        tick();
        check_all_zero("reset");
        rst       = 1'b0;
        row_ready = 1'b1;
        tick();
        tick();
        check("idle_ready_ignored", row_valid, 0);
        check("idle_busy", busy, 0);

        run_window(0, 0, -1, 0, -1);
        run_window(13, 2, -1, 0, -1);
        run_window(21, 5, 3, 0, -1);
        run_window(7, 9, -1, (1 << 2) | (1 << 7), -1);
        run_window(3, 4, -1, 0, 6);
        run_window(3, 4, -1, 0, -1);
        run_window(4093, 4095, -1, 0, -1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
